// File: rtl/sys_defs.sv
// Shared memory-side definitions: retired store entry, memory size encoding
// and the store drain FSM states.
package sys_defs;

    localparam int XLEN     = 32;
    localparam int LQ_IDX_W = 3;

    // mem_size[1:0] selects the access size; mem_size[2] is the load sign bit,
    // which plays no part in a store.
    typedef logic [2:0] MEM_SIZE;
    localparam logic [1:0] MEM_BYTE = 2'd0;
    localparam logic [1:0] MEM_HALF = 2'd1;
    localparam logic [1:0] MEM_WORD = 2'd2;

    typedef struct packed {
        logic [XLEN-1:0]     addr;
        logic                valid;
        logic [XLEN-1:0]     value;
        logic [LQ_IDX_W-1:0] LQ_idx;
        MEM_SIZE             mem_size;
    } SQ_ENTRY_PACKET;

    typedef enum logic [1:0] {
        DR_IDLE = 2'd0,
        DR_REQ  = 2'd1,
        DR_WAIT = 2'd2,
        DR_POP  = 2'd3
    } DRAIN_STATE;

endpackage

// File: rtl/store_align_gen.sv
// Store lane alignment: turns a sized store into word-port byte enables and
// lane-shifted data, and flags accesses that cross their natural alignment.
//   addr_lo_i  : addr[1:0] of the store
//   size_i     : mem_size[1:0] (0 byte, 1 half, 2 word, 3 illegal)
//   value_i    : store value, right-justified
//   be_o       : byte enables on the word port
//   data_o     : value masked to its size and shifted to its byte lane
//   misalign_o : access is misaligned (or size is illegal)
module store_align_gen
    import sys_defs::*;
(
    input  logic [1:0]  addr_lo_i,
    input  logic [1:0]  size_i,
    input  logic [31:0] value_i,
    output logic [3:0]  be_o,
    output logic [31:0] data_o,
    output logic        misalign_o
);

    logic [3:0]  be_base;
    logic [31:0] masked;

    always_comb begin
        be_base    = 4'b0000;
        masked     = '0;
        misalign_o = 1'b0;
        case (size_i)
            MEM_BYTE: begin
                be_base = 4'b0001;
                masked  = {24'b0, value_i[7:0]};
            end
            MEM_HALF: begin
                be_base    = 4'b0011;
                masked     = {16'b0, value_i[15:0]};
                misalign_o = addr_lo_i[0];
            end
            MEM_WORD: begin
                be_base    = 4'b1111;
                masked     = value_i;
                misalign_o = |addr_lo_i;
            end
            default: misalign_o = 1'b1;
        endcase
    end

    assign be_o   = be_base << addr_lo_i;
    assign data_o = masked << {addr_lo_i, 3'b000};

endmodule

// File: rtl/store_drain_unit.sv
// Store drain unit: takes the head of the retire store buffer, issues one
// aligned word write per entry, waits for the memory ack (reissuing after a
// timeout) and only then pops the entry.
//   clk_i, rst_ni      : clock, async active-low reset
//   sb_empty_i/sb_head_i : store buffer head
//   sb_rd_en_o         : one-cycle pop of the head
//   mem_req_*          : store request port (valid/ready, addr, data, be)
//   mem_ack_i          : write complete
//   misalign_err_o     : pulse when a misaligned entry is dropped
//   drained_o          : buffer empty and nothing in flight
//   stall_cycles_o     : saturating REQ+WAIT cycle count
//   retry_cnt_o        : saturating timeout reissue count
module store_drain_unit
    import sys_defs::*;
#(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             sb_empty_i,
    input  SQ_ENTRY_PACKET   sb_head_i,
    output logic             sb_rd_en_o,
    output logic             mem_req_valid_o,
    input  logic             mem_req_ready_i,
    output logic [31:0]      mem_req_addr_o,
    output logic [31:0]      mem_req_data_o,
    output logic [3:0]       mem_req_be_o,
    input  logic             mem_ack_i,
    output logic             misalign_err_o,
    output logic             drained_o,
    output logic [CNT_W-1:0] stall_cycles_o,
    output logic [CNT_W-1:0] retry_cnt_o
);

    localparam int               TMR_W    = $clog2(TIMEOUT);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    DRAIN_STATE       state_q, state_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      data_q, data_d;
    logic [3:0]       be_q, be_d;
    logic             mis_q, mis_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] retry_q, retry_d;

    logic [3:0]  al_be;
    logic [31:0] al_data;
    logic        al_mis;

    // LQ index and sign bit ride along in the entry but a store ignores them.
    logic unused_head;
    assign unused_head = ^{sb_head_i.LQ_idx, sb_head_i.mem_size[2]};

    store_align_gen u_align (
        .addr_lo_i  (sb_head_i.addr[1:0]),
        .size_i     (sb_head_i.mem_size[1:0]),
        .value_i    (sb_head_i.value),
        .be_o       (al_be),
        .data_o     (al_data),
        .misalign_o (al_mis)
    );

    logic timeout_hit;
    assign timeout_hit = (state_q == DR_WAIT) && !mem_ack_i && (timer_q == TMR_LAST);

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= DR_IDLE;
        else         state_q <= state_d;
    end

    // Next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            DR_IDLE: if (!sb_empty_i)
                         state_d = (sb_head_i.valid && !al_mis) ? DR_REQ : DR_POP;
            DR_REQ:  if (mem_req_ready_i)
                         state_d = mem_ack_i ? DR_POP : DR_WAIT;
            // An ack in the last timeout cycle takes priority over the reissue.
            DR_WAIT: if (mem_ack_i)        state_d = DR_POP;
                     else if (timeout_hit) state_d = DR_REQ;
            DR_POP:  state_d = DR_IDLE;
            default: state_d = DR_IDLE;
        endcase
    end

    // Outputs, decoded from registered state only
    always_comb begin
        mem_req_valid_o = (state_q == DR_REQ);
        sb_rd_en_o      = (state_q == DR_POP);
        misalign_err_o  = (state_q == DR_POP) && mis_q;
        drained_o       = sb_empty_i && (state_q == DR_IDLE);
    end

    assign mem_req_addr_o = addr_q;
    assign mem_req_data_o = data_q;
    assign mem_req_be_o   = be_q;
    assign stall_cycles_o = stall_q;
    assign retry_cnt_o    = retry_q;

    // Request registers, WAIT timer and counters
    always_comb begin
        addr_d  = addr_q;
        data_d  = data_q;
        be_d    = be_q;
        mis_d   = mis_q;
        timer_d = timer_q;
        stall_d = stall_q;
        retry_d = retry_q;

        if (state_q == DR_IDLE && !sb_empty_i) begin
            mis_d = sb_head_i.valid && al_mis;
            if (sb_head_i.valid && !al_mis) begin
                addr_d = {sb_head_i.addr[31:2], 2'b00};
                data_d = al_data;
                be_d   = al_be;
            end
        end

        // Held at zero through REQ so every WAIT visit starts a fresh window.
        if (state_q == DR_REQ)       timer_d = '0;
        else if (state_q == DR_WAIT) timer_d = timer_q + TMR_W'(1);

        if ((state_q == DR_REQ || state_q == DR_WAIT) && stall_q != '1)
            stall_d = stall_q + CNT_W'(1);
        if (timeout_hit && retry_q != '1)
            retry_d = retry_q + CNT_W'(1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_q  <= '0;
            data_q  <= '0;
            be_q    <= '0;
            mis_q   <= 1'b0;
            timer_q <= '0;
            stall_q <= '0;
            retry_q <= '0;
        end else begin
            addr_q  <= addr_d;
            data_q  <= data_d;
            be_q    <= be_d;
            mis_q   <= mis_d;
            timer_q <= timer_d;
            stall_q <= stall_d;
            retry_q <= retry_d;
        end
    end

    a_pop_legal: assert property (@(posedge clk_i) disable iff (!rst_ni)
        sb_rd_en_o |-> (state_q == DR_POP) && !sb_empty_i);

endmodule
